branch_predictor_btb: RTL and testbench

//  Parametrised next-PC predictor for the pipelined TSC CPU IF stage: direct-mapped BTB + per-entry

---
 rtl/branch_predictor_btb.sv | 144 ++++++++++++++
 tb/tb_branch_predictor_btb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_btb
//  Description : Direct-mapped BTB next-PC predictor with per-entry direction
//                counters, four selectable prediction modes and a saturating
//                mispredict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_if,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_target,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_ctrl,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    output logic [15:0]          mispredict_cnt
);

    localparam int c_depth = 2 ** INDEX_BITS;
    localparam int c_tag_w = WORD_SIZE - INDEX_BITS;
    localparam int c_ctr_w = (MODE == 3) ? 2 : CTR_BITS;
    localparam logic [c_ctr_w-1:0] c_ctr_max  = {c_ctr_w{1'b1}};
    localparam logic [c_ctr_w-1:0] c_weak_t   = c_ctr_w'(1) << (c_ctr_w - 1);
    localparam logic [c_ctr_w-1:0] c_weak_nt  = c_weak_t - c_ctr_w'(1);

    if ((CTR_BITS < 1) || (CTR_BITS > 4)) begin : g_bad_ctr_bits
        $error("branch_predictor_btb: CTR_BITS must be in 1..4");
    end
    if ((MODE == 3) && (CTR_BITS != 2)) begin : g_bad_mode3
        $error("branch_predictor_btb: MODE 3 requires CTR_BITS == 2");
    end
    if ((MODE < 0) || (MODE > 3)) begin : g_bad_mode
        $error("branch_predictor_btb: MODE must be in 0..3");
    end

    logic                 valid_q  [c_depth];
    logic [c_tag_w-1:0]   tag_q    [c_depth];
    logic [WORD_SIZE-1:0] target_q [c_depth];
    logic [c_ctr_w-1:0]   ctr_q    [c_depth];
    logic                 valid_d  [c_depth];
    logic [c_tag_w-1:0]   tag_d    [c_depth];
    logic [WORD_SIZE-1:0] target_d [c_depth];
    logic [c_ctr_w-1:0]   ctr_d    [c_depth];
    logic [15:0]          cnt_q;
    logic [15:0]          cnt_d;

    // Hysteresis jumps straight to strong on a second agreeing outcome and
    // drops to strong-opposite from the weak state.
    function automatic logic [c_ctr_w-1:0] train_ctr(input logic [c_ctr_w-1:0] c,
                                                      input logic t);
        logic [c_ctr_w-1:0] n;
        if (MODE == 3) begin
            if (t) n = (c == '0) ? c_ctr_w'(1) : c_ctr_max;
            else   n = (c == c_ctr_max) ? (c_ctr_max - c_ctr_w'(1)) : '0;
        end else begin
            if (t) n = (c == c_ctr_max) ? c : c + c_ctr_w'(1);
            else   n = (c == '0) ? c : c - c_ctr_w'(1);
        end
        return n;
    endfunction

    logic [INDEX_BITS-1:0] lk_idx;
    logic                  lk_hit;
    logic [INDEX_BITS-1:0] up_idx;
    logic [c_tag_w-1:0]    up_tag;
    logic                  up_hit;

    assign lk_idx = pc_if[INDEX_BITS-1:0];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == pc_if[WORD_SIZE-1:INDEX_BITS]);
    assign up_idx = upd_pc[INDEX_BITS-1:0];
    assign up_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        pred_taken = 1'b0;
        case (MODE)
            0:       pred_taken = 1'b0;
            1:       pred_taken = lk_hit;
            default: pred_taken = lk_hit && ctr_q[lk_idx][c_ctr_w-1];
        endcase
    end

    assign pred_target    = target_q[lk_idx];
    assign pred_next_pc   = pred_taken ? target_q[lk_idx] : (pc_if + WORD_SIZE'(1));
    assign mispredict_cnt = cnt_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        cnt_d    = cnt_q;
        if (upd_valid) begin
            if (upd_is_ctrl) begin
                if (up_hit) begin
                    target_d[up_idx] = upd_target;
                    ctr_d[up_idx]    = train_ctr(ctr_q[up_idx], upd_taken);
                end else begin
                    valid_d[up_idx]  = 1'b1;
                    tag_d[up_idx]    = up_tag;
                    target_d[up_idx] = upd_target;
                    ctr_d[up_idx]    = upd_taken ? c_weak_t : c_weak_nt;
                end
            end else if (up_hit) begin
                // A non-branch now occupies this PC: drop the stale entry.
                valid_d[up_idx] = 1'b0;
            end
            if (upd_mispredict && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_btb
//  Description : Directed self-checking bench; a MODE 2 and a MODE 3 instance
//                share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_if;
    logic        upd_valid, upd_is_ctrl, upd_taken, upd_mispredict;
    logic [15:0] upd_pc, upd_target;

    logic        t2, t3;
    logic [15:0] tg2, tg3, nx2, nx3, cnt2, cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .MODE(2)) u2 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .pred_taken(t2), .pred_target(tg2), .pred_next_pc(nx2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_ctrl(upd_is_ctrl),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(cnt2)
    );

    branch_predictor_btb #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .MODE(3)) u3 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .pred_taken(t3), .pred_target(tg3), .pred_next_pc(nx3),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_ctrl(upd_is_ctrl),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [15:0] pc, input logic ctrl, input logic tk,
                       input logic [15:0] tgt, input logic mis);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_is_ctrl = ctrl;
        upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
        @(posedge clk);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        pc_if = pc;
        #1;
    endtask

    task automatic chk2(input string tag, input logic et, input logic [15:0] en);
        chk({tag, "_m2_taken"}, {31'd0, t2}, {31'd0, et});
        chk({tag, "_m2_next"}, {16'd0, nx2}, {16'd0, en});
    endtask

    task automatic chk3(input string tag, input logic et, input logic [15:0] en);
        chk({tag, "_m3_taken"}, {31'd0, t3}, {31'd0, et});
        chk({tag, "_m3_next"}, {16'd0, nx3}, {16'd0, en});
    endtask

    initial begin
        reset = 1'b1; pc_if = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_ctrl = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        look(16'h0010);
        chk2("reset", 1'b0, 16'h0011);
        chk3("reset", 1'b0, 16'h0011);
        chk("reset_cnt", {16'd0, cnt2}, 32'd0);

        // Allocate taken: weak-taken counter predicts taken
        upd(16'h0012, 1, 1, 16'h0040, 0);
        look(16'h0012);
        chk2("alloc", 1'b1, 16'h0040);
        chk3("alloc", 1'b1, 16'h0040);
        chk("alloc_target", {16'd0, tg2}, 32'h0040);

        upd(16'h0012, 1, 0, 16'h0040, 0);           // m2 ctr 1, m3 00
        chk2("nt1", 1'b0, 16'h0013);
        chk3("nt1", 1'b0, 16'h0013);
        upd(16'h0012, 1, 0, 16'h0040, 0);           // m2 0
        upd(16'h0012, 1, 0, 16'h0040, 0);           // m2 0 (floor)
        chk2("nt3", 1'b0, 16'h0013);
        upd(16'h0012, 1, 1, 16'h0040, 0);           // m2 1, m3 01
        chk2("t1", 1'b0, 16'h0013);
        chk3("t1", 1'b0, 16'h0013);
        upd(16'h0012, 1, 1, 16'h0040, 0);           // m2 2, m3 11
        chk2("t2", 1'b1, 16'h0040);
        chk3("t2", 1'b1, 16'h0040);
        upd(16'h0012, 1, 1, 16'h0040, 0);           // m2 3
        upd(16'h0012, 1, 1, 16'h0040, 0);           // m2 3 (ceiling)
        upd(16'h0012, 1, 0, 16'h0040, 0);           // m2 2, m3 10
        chk2("sat_nt", 1'b1, 16'h0040);
        chk3("hyst_nt1", 1'b1, 16'h0040);
        upd(16'h0012, 1, 0, 16'h0040, 0);           // m2 1, m3 00
        chk2("sat_nt2", 1'b0, 16'h0013);
        chk3("hyst_nt2", 1'b0, 16'h0013);
        upd(16'h0012, 1, 1, 16'h0040, 0);           // m2 2, m3 01
        chk2("rt", 1'b1, 16'h0040);
        chk3("hyst_t", 1'b0, 16'h0013);
        upd(16'h0012, 1, 1, 16'h0050, 0);           // target refresh on hit
        chk2("retarget", 1'b1, 16'h0050);
        chk3("retarget", 1'b1, 16'h0050);

        // Alias handling on index 2
        upd(16'h0022, 0, 0, 16'h0000, 0);
        chk2("alias_keep", 1'b1, 16'h0050);
        look(16'h0022);
        chk2("alias_nohit", 1'b0, 16'h0023);
        upd(16'h0012, 0, 0, 16'h0000, 0);
        look(16'h0012);
        chk2("inval", 1'b0, 16'h0013);
        chk3("inval", 1'b0, 16'h0013);
        upd(16'h0022, 1, 1, 16'h0099, 0);
        look(16'h0022);
        chk2("realloc", 1'b1, 16'h0099);
        chk3("realloc", 1'b1, 16'h0099);
        look(16'h0012);
        chk2("realloc_old", 1'b0, 16'h0013);

        // Same-cycle update and lookup returns old contents
        @(negedge clk);
        pc_if = 16'h0015; upd_valid = 1'b1; upd_pc = 16'h0015; upd_is_ctrl = 1'b1;
        upd_taken = 1'b1; upd_target = 16'h0077;
        #1;
        chk2("samecyc_old", 1'b0, 16'h0016);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk2("samecyc_new", 1'b1, 16'h0077);
        chk3("samecyc_new", 1'b1, 16'h0077);

        // Strobe low: non-ctrl on a hit must be ignored
        @(negedge clk);
        upd_is_ctrl = 1'b0; upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        upd_mispredict = 1'b0;
        chk2("novalid", 1'b1, 16'h0077);
        chk("novalid_cnt", {16'd0, cnt2}, 32'd0);

        look(16'hFFFF);
        chk2("wrap", 1'b0, 16'h0000);

        // Mispredict statistics
        for (int i = 0; i < 16; i++) upd(16'h0030, 0, 0, 16'h0000, 1);
        chk("cnt16_m2", {16'd0, cnt2}, 32'd16);
        chk("cnt16_m3", {16'd0, cnt3}, 32'd16);
        @(negedge clk);
        force u2.cnt_q = 16'hFFFF;
        #1;
        release u2.cnt_q;
        #1;
        chk("cnt_forced", {16'd0, cnt2}, 32'hFFFF);
        upd(16'h0030, 0, 0, 16'h0000, 1);
        chk("cnt_sat1", {16'd0, cnt2}, 32'hFFFF);
        chk("cnt17_m3", {16'd0, cnt3}, 32'd17);
        upd(16'h0030, 0, 0, 16'h0000, 1);
        chk("cnt_sat2", {16'd0, cnt2}, 32'hFFFF);

        // Asynchronous reset in the middle of a training stream
        look(16'h0015);
        chk2("pre_rst", 1'b1, 16'h0077);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 16'h0015; upd_is_ctrl = 1'b1; upd_taken = 1'b1;
        upd_target = 16'h0123; upd_mispredict = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk2("rst_async", 1'b0, 16'h0016);
        chk("rst_async_cnt", {16'd0, cnt2}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        @(posedge clk);
        #1;
        look(16'h0015);
        chk2("rst_hold", 1'b0, 16'h0016);
        chk3("rst_hold", 1'b0, 16'h0016);
        look(16'h0022);
        chk2("rst_clear", 1'b0, 16'h0023);
        chk("rst_cnt3", {16'd0, cnt3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
